qsort_range_scheduler: RTL and testbench

Controller that sequences the quicksort partition engine over an N-element array. It keeps a LIFO stack of pending (lo, hi) index ranges, issues one partition request at a time and collects the resulting pivot position. It then pushes the two sub-ranges and signals completion when no work remains. It sits between the host start/done interface and the partition datapath, and replaces ad-hoc left/right valid tracking with an explicit work stack.

---
 rtl/qsort_pkg.sv | 21 ++
 rtl/qsort_range_stack.sv | 56 +++++
 rtl/qsort_range_scheduler.sv | 149 ++++++++++++++
 tb/tb_qsort_range_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/qsort_pkg.sv
// Shared types for the quicksort scheduler and partition engine: FSM states,
// the (lo, hi) range record and the default array size.
package qsort_pkg;

    localparam int QS_N_ELEM = 8;
    localparam int QS_IDX_W  = $clog2(QS_N_ELEM);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        ISSUE,
        PUSH,
        DONE
    } qs_state_t;

    typedef struct packed {
        logic [QS_IDX_W-1:0] lo;
        logic [QS_IDX_W-1:0] hi;
    } qs_range_t;

endpackage

// File: rtl/qsort_range_stack.sv
// LIFO of pending (lo, hi) ranges. Pushes 0, 1 or 2 entries per cycle
// (push_a lands deeper, push_b on top) or pops one; clr restarts from empty.
module qsort_range_stack
    import qsort_pkg::*;
#(
    parameter int DEPTH = QS_N_ELEM
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       pop,
    input  logic [1:0] push_cnt,
    input  qs_range_t  push_a,
    input  qs_range_t  push_b,
    output logic       empty,
    output qs_range_t  top,
    output logic       would_overflow
);

    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int AW   = $clog2(DEPTH);

    qs_range_t       mem [DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] base;
    logic [AW-1:0]   top_idx;
    logic [AW-1:0]   wr_idx0;
    logic [AW-1:0]   wr_idx1;

    assign base           = clr ? '0 : sp;
    assign empty          = (sp == '0);
    assign top_idx        = AW'(sp - SP_W'(1));
    assign top            = empty ? '0 : mem[top_idx];
    assign wr_idx0        = AW'(base);
    assign wr_idx1        = AW'(base + SP_W'(1));
    assign would_overflow = (int'(base) + int'(push_cnt)) > DEPTH;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end else if (!would_overflow && (clr || push_cnt != 2'd0)) begin
            sp <= base + SP_W'(push_cnt);
        end
    end

    // NOTE: storage is deliberately not reset; sp alone defines which entries are valid.
    always_ff @(posedge clock) begin
        if (!would_overflow) begin
            if (push_cnt != 2'd0) mem[wr_idx0] <= push_a;
            if (push_cnt == 2'd2) mem[wr_idx1] <= push_b;
        end
    end

endmodule

// File: rtl/qsort_range_scheduler.sv
// Work-stack scheduler that drives the partition engine one range at a time.
// Stack entries use qsort_pkg::qs_range_t, so N_ELEM tracks QS_N_ELEM.
module qsort_range_scheduler
    import qsort_pkg::*;
#(
    parameter int N_ELEM      = QS_N_ELEM,
    parameter int IDX_W       = $clog2(N_ELEM),
    parameter int STACK_DEPTH = N_ELEM
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             part_req,
    output logic [IDX_W-1:0] part_lo,
    output logic [IDX_W-1:0] part_hi,
    input  logic             part_ack,
    input  logic [IDX_W-1:0] part_pivot,
    output logic [IDX_W+3:0] partitions
);

    qs_state_t        state, state_nx;
    logic [IDX_W-1:0] lo_r, hi_r, p_r;
    logic             stk_clr, stk_pop, stk_empty, stk_overflow;
    logic [1:0]       push_cnt;
    qs_range_t        push_a, push_b, stk_top;
    logic             clr_run, cap_top, cap_pivot, part_inc, err_set;
    logic             right_ok, left_ok;
    logic [IDX_W-1:0] right_lo, left_hi;

    qsort_range_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clock          (clock),
        .reset          (reset),
        .clr            (stk_clr),
        .pop            (stk_pop),
        .push_cnt       (push_cnt),
        .push_a         (push_a),
        .push_b         (push_b),
        .empty          (stk_empty),
        .top            (stk_top),
        .would_overflow (stk_overflow)
    );

    // Sub-range bounds are only stepped under their guards, so nothing wraps.
    assign right_ok = (p_r < hi_r);
    assign left_ok  = (p_r > lo_r);
    assign right_lo = right_ok ? p_r + IDX_W'(1) : p_r;
    assign left_hi  = left_ok  ? p_r - IDX_W'(1) : p_r;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nx  = state;
        stk_clr   = 1'b0;
        stk_pop   = 1'b0;
        push_cnt  = 2'd0;
        push_a    = '0;
        push_b    = '0;
        clr_run   = 1'b0;
        cap_top   = 1'b0;
        cap_pivot = 1'b0;
        part_inc  = 1'b0;
        err_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stk_clr   = 1'b1;
                    push_cnt  = 2'd1;
                    push_a.hi = IDX_W'(N_ELEM - 1);
                    clr_run   = 1'b1;
                    state_nx  = POP;
                end
            end
            POP: begin
                if (stk_empty) begin
                    state_nx = DONE;
                end else begin
                    stk_pop = 1'b1;
                    cap_top = 1'b1;
                    if (stk_top.lo < stk_top.hi) begin
                        part_inc = 1'b1;
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (part_ack) begin
                    if (part_pivot < lo_r || part_pivot > hi_r) begin
                        err_set  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        cap_pivot = 1'b1;
                        state_nx  = PUSH;
                    end
                end
            end
            PUSH: begin
                // Right range goes deeper so the left range is popped first.
                push_cnt  = {1'b0, right_ok} + {1'b0, left_ok};
                push_b.lo = lo_r;
                push_b.hi = left_hi;
                if (right_ok) begin
                    push_a.lo = right_lo;
                    push_a.hi = hi_r;
                end else begin
                    push_a = push_b;
                end
                err_set  = stk_overflow;
                state_nx = stk_overflow ? DONE : POP;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lo_r       <= '0;
            hi_r       <= '0;
            p_r        <= '0;
            err        <= 1'b0;
            partitions <= '0;
        end else begin
            state <= state_nx;
            if (cap_top) begin
                lo_r <= stk_top.lo;
                hi_r <= stk_top.hi;
            end
            if (cap_pivot) p_r <= part_pivot;
            if (clr_run)      err <= 1'b0;
            else if (err_set) err <= 1'b1;
            if (clr_run) begin
                partitions <= '0;
            end else if (part_inc && partitions != '1) begin
                partitions <= partitions + (IDX_W+4)'(1);
            end
        end
    end

    // Decoded from state so an asynchronous reset drops them at once.
    assign busy     = (state == POP) || (state == ISSUE) || (state == PUSH);
    assign done     = (state == DONE);
    assign part_req = (state == ISSUE);
    assign part_lo  = lo_r;
    assign part_hi  = hi_r;

endmodule

// File: tb/tb_qsort_range_scheduler.sv
// Scoreboarded bench: expected part_req ranges are queued per run and popped
// as the engine model sees each new request.
module tb_qsort_range_scheduler;

    localparam int N      = 8;
    localparam int IW     = $clog2(N);
    localparam int BUDGET = 400;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          part_ack = 1'b0;
    logic [IW-1:0] part_pivot = '0;
    logic          busy, done, err, part_req;
    logic [IW-1:0] part_lo, part_hi;
    logic [IW+3:0] partitions;

    typedef struct {
        int lo;
        int hi;
    } span_t;

    span_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    qsort_range_scheduler #(.N_ELEM(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .part_req   (part_req),
        .part_lo    (part_lo),
        .part_hi    (part_hi),
        .part_ack   (part_ack),
        .part_pivot (part_pivot),
        .partitions (partitions)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic expect_span(input int lo, input int hi);
        span_t s;
        s.lo = lo;
        s.hi = hi;
        exp_q.push_back(s);
    endtask

    // p = hi on every range: a left-only chain (0,7),(0,6)..(0,1).
    task automatic expect_hi_chain();
        for (int k = N - 1; k >= 1; k--) expect_span(0, k);
    endtask

    function automatic logic [IW-1:0] pivot_of(input int mode, input int lo, input int hi);
        int p;
        case (mode)
            1:       p = (lo == 0 && hi == N - 1) ? 3 : (lo + hi) / 2;
            2:       p = (lo == 0 && hi == N - 1) ? 4 : ((lo == 0 && hi == 3) ? 6 : hi);
            default: p = hi;
        endcase
        return IW'(p);
    endfunction

    task automatic run_sort(input string tag, input int mode, input int delay, input bit exp_err,
                            input int exp_parts, input int exp_lat, input bit chk_timing,
                            input bit double_start);
        bit    in_req = 1'b0;
        bit    expect_low = 1'b0;
        bit    first = 1'b1;
        bit    fin = 1'b0;
        int    wait_cnt = 0;
        int    ack_cyc = -1;
        int    prev_rise = -1;
        span_t cur;
        cur.lo = 0;
        cur.hi = 0;
        @(posedge clock); #1;
        start = 1'b1;
        for (int cyc = 1; cyc <= BUDGET && !fin; cyc++) begin
            @(posedge clock); #1;
            part_ack = 1'b0;
            start = (double_start && cyc == 3);
            if (cyc == 1) begin
                check({tag, "_busy_after_start"}, int'(busy), 1);
                check({tag, "_err_cleared"}, int'(err), 0);
            end
            if (expect_low) begin
                check({tag, "_req_low_after_ack"}, int'(part_req), 0);
                expect_low = 1'b0;
            end
            if (done) begin
                fin = 1'b1;
                check({tag, "_busy_at_done"}, int'(busy), 0);
                check({tag, "_err_at_done"}, int'(err), int'(exp_err));
                check({tag, "_partitions"}, int'(partitions), exp_parts);
                check({tag, "_unissued_ranges"}, exp_q.size(), 0);
                check({tag, "_ack_to_done"}, cyc - ack_cyc, exp_lat);
            end else if (part_req) begin
                if (!in_req) begin
                    in_req   = 1'b1;
                    wait_cnt = 0;
                    if (first) check({tag, "_start_to_req"}, cyc, 2);
                    first = 1'b0;
                    if (chk_timing && prev_rise >= 0)
                        check({tag, "_req_interval"}, cyc - prev_rise, delay + 3);
                    prev_rise = cyc;
                    check({tag, "_req_expected"}, int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) cur = exp_q.pop_front();
                    check({tag, "_part_lo"}, int'(part_lo), cur.lo);
                    check({tag, "_part_hi"}, int'(part_hi), cur.hi);
                end else begin
                    check({tag, "_lo_stable"}, int'(part_lo), cur.lo);
                    check({tag, "_hi_stable"}, int'(part_hi), cur.hi);
                end
                if (wait_cnt == delay) begin
                    part_ack   = 1'b1;
                    part_pivot = pivot_of(mode, cur.lo, cur.hi);
                    in_req     = 1'b0;
                    expect_low = 1'b1;
                    ack_cyc    = cyc;
                end else begin
                    wait_cnt++;
                end
            end
        end
        start    = 1'b0;
        part_ack = 1'b0;
        check({tag, "_finished_in_budget"}, int'(fin), 1);
        @(posedge clock); #1;
        check({tag, "_done_one_cycle"}, int'(done), 0);
        check({tag, "_idle_after_done"}, int'(busy), 0);
        exp_q.delete();
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_part_req", int'(part_req), 0);
        check("rst_part_lo", int'(part_lo), 0);
        check("rst_part_hi", int'(part_hi), 0);
        check("rst_partitions", int'(partitions), 0);
        reset = 1'b0;

        expect_hi_chain();
        run_sort("hi_pivot", 0, 0, 1'b0, 7, 4, 1'b1, 1'b0);

        expect_span(0, 7);
        expect_span(0, 2);
        expect_span(4, 7);
        expect_span(6, 7);
        run_sort("mid_pivot", 1, 0, 1'b0, 4, 4, 1'b0, 1'b0);

        expect_hi_chain();
        run_sort("slow_ack", 0, 5, 1'b0, 7, 4, 1'b1, 1'b0);

        expect_span(0, 7);
        expect_span(0, 3);
        run_sort("bad_pivot", 2, 0, 1'b1, 2, 1, 1'b0, 1'b0);

        expect_hi_chain();
        run_sort("after_err", 0, 0, 1'b0, 7, 4, 1'b1, 1'b0);

        // Reset while a request is outstanding, then a stray ack around release.
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !part_req; i++) begin
            @(posedge clock); #1;
        end
        check("mid_rst_req_seen", int'(part_req), 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req_async", int'(part_req), 0);
        check("mid_rst_busy_async", int'(busy), 0);
        part_ack   = 1'b1;
        part_pivot = IW'(N - 1);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        part_ack = 1'b0;
        check("post_rst_partitions", int'(partitions), 0);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_req", int'(part_req), 0);

        expect_hi_chain();
        run_sort("after_rst", 0, 0, 1'b0, 7, 4, 1'b1, 1'b0);

        expect_hi_chain();
        run_sort("double_start", 0, 0, 1'b0, 7, 4, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
